rover_pwm: RTL and testbench

ROVER_PWM -- requirements
Module: rover_pwm

---
 rtl/rover_pwm.sv | 209 ++++++++++++++++++++
 tb/tb_rover_pwm.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rover_pwm.sv
// Three-wheel PWM generator with an Avalon-MM register file.
// Staged period/duty/dir registers move into the active set only at a wrap or on enable.
`timescale 1ns/1ps

module rover_pwm (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        tick_in,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [2:0]  address,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic [2:0]  pwm_out,
   output logic [2:0]  dir_out,
   output logic        irq
);

   localparam logic [15:0] PERIOD_RST = 16'd999;

   localparam logic [2:0] ADDR_STATUS  = 3'd0;
   localparam logic [2:0] ADDR_CONTROL = 3'd1;
   localparam logic [2:0] ADDR_PERIOD  = 3'd2;
   localparam logic [2:0] ADDR_DUTY0   = 3'd3;
   localparam logic [2:0] ADDR_DUTY1   = 3'd4;
   localparam logic [2:0] ADDR_DUTY2   = 3'd5;
   localparam logic [2:0] ADDR_DIR     = 3'd6;
   localparam logic [2:0] ADDR_COUNTER = 3'd7;

   logic        enable_q,       enable_d;
   logic        irq_en_q,       irq_en_d;
   logic        use_tick_q,     use_tick_d;
   logic        brake_q,        brake_d;
   logic [15:0] period_stage_q, period_stage_d;
   logic [15:0] period_act_q,   period_act_d;
   logic [15:0] duty_stage_q [3];
   logic [15:0] duty_stage_d [3];
   logic [15:0] duty_act_q   [3];
   logic [15:0] duty_act_d   [3];
   logic [2:0]  dir_stage_q,    dir_stage_d;
   logic [2:0]  dir_act_q,      dir_act_d;
   logic [15:0] counter_q,      counter_d;
   logic        period_done_q,  period_done_d;
   logic        running_q,      running_d;
   logic [15:0] readdata_q,     readdata_d;
   logic [2:0]  pwm_q,          pwm_d;
   logic [2:0]  dir_out_q,      dir_out_d;

   logic wr_en;
   logic wr_ctrl;
   logic en_rise;
   logic en_fall;
   logic step;
   logic at_top;
   logic wrap;
   logic load_act;

   assign wr_en    = chipselect & ~write_n;
   assign wr_ctrl  = wr_en && (address == ADDR_CONTROL);
   assign en_rise  = wr_ctrl &&  writedata[0] && !enable_q;
   assign en_fall  = wr_ctrl && !writedata[0] &&  enable_q;
   assign step     = enable_q && (use_tick_q ? tick_in : 1'b1);
   assign at_top   = (counter_q == period_act_q);
   // A disabling write takes precedence over a wrap landing on the same cycle.
   assign wrap     = step && at_top && !en_fall;
   assign load_act = wrap || en_rise;

   always_comb begin
      enable_d       = enable_q;
      irq_en_d       = irq_en_q;
      use_tick_d     = use_tick_q;
      brake_d        = brake_q;
      period_stage_d = period_stage_q;
      dir_stage_d    = dir_stage_q;
      for (int i = 0; i < 3; i++) begin
         duty_stage_d[i] = duty_stage_q[i];
      end

      if (wr_en) begin
         case (address)
            ADDR_CONTROL: begin
               enable_d   = writedata[0];
               irq_en_d   = writedata[1];
               use_tick_d = writedata[2];
               brake_d    = writedata[3];
            end
            ADDR_PERIOD: period_stage_d  = writedata;
            ADDR_DUTY0:  duty_stage_d[0] = writedata;
            ADDR_DUTY1:  duty_stage_d[1] = writedata;
            ADDR_DUTY2:  duty_stage_d[2] = writedata;
            ADDR_DIR:    dir_stage_d     = writedata[2:0];
            default: ;
         endcase
      end
   end

   // Active copies load from the pre-write staged values, so a write on the
   // wrap cycle is only picked up one period later.
   always_comb begin
      period_act_d = load_act ? period_stage_q : period_act_q;
      dir_act_d    = load_act ? dir_stage_q    : dir_act_q;
      for (int i = 0; i < 3; i++) begin
         duty_act_d[i] = load_act ? duty_stage_q[i] : duty_act_q[i];
      end
   end

   always_comb begin
      counter_d = counter_q;
      if (en_rise || en_fall) begin
         counter_d = 16'd0;
      end else if (step) begin
         counter_d = at_top ? 16'd0 : counter_q + 16'd1;
      end
   end

   always_comb begin
      period_done_d = period_done_q;
      if (wrap) begin
         period_done_d = 1'b1;
      end else if (wr_en && (address == ADDR_STATUS)) begin
         period_done_d = 1'b0;
      end
   end

   always_comb begin
      running_d = running_q;
      if (en_rise) begin
         running_d = 1'b1;
      end else if (en_fall) begin
         running_d = 1'b0;
      end
   end

   // Outputs are registered from next-state values so they line up with counter_q.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_pwm
         assign pwm_d[gi] = enable_d & ~brake_d & (counter_d < duty_act_d[gi]);
      end
   endgenerate

   assign dir_out_d = brake_d ? dir_out_q : dir_act_d;

   always_comb begin
      readdata_d = 16'd0;
      case (address)
         ADDR_STATUS:  readdata_d = {14'd0, running_q, period_done_q};
         ADDR_CONTROL: readdata_d = {12'd0, brake_q, use_tick_q, irq_en_q, enable_q};
         ADDR_PERIOD:  readdata_d = period_stage_q;
         ADDR_DUTY0:   readdata_d = duty_stage_q[0];
         ADDR_DUTY1:   readdata_d = duty_stage_q[1];
         ADDR_DUTY2:   readdata_d = duty_stage_q[2];
         ADDR_DIR:     readdata_d = {13'd0, dir_stage_q};
         ADDR_COUNTER: readdata_d = counter_q;
         default:      readdata_d = 16'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable_d_reset();
      end else begin
         enable_q       <= enable_d;
         irq_en_q       <= irq_en_d;
         use_tick_q     <= use_tick_d;
         brake_q        <= brake_d;
         period_stage_q <= period_stage_d;
         period_act_q   <= period_act_d;
         dir_stage_q    <= dir_stage_d;
         dir_act_q      <= dir_act_d;
         for (int i = 0; i < 3; i++) begin
            duty_stage_q[i] <= duty_stage_d[i];
            duty_act_q[i]   <= duty_act_d[i];
         end
         counter_q      <= counter_d;
         period_done_q  <= period_done_d;
         running_q      <= running_d;
         readdata_q     <= readdata_d;
         pwm_q          <= pwm_d;
         dir_out_q      <= dir_out_d;
      end
   end

   task automatic enable_d_reset();
      enable_q       <= 1'b0;
      irq_en_q       <= 1'b0;
      use_tick_q     <= 1'b0;
      brake_q        <= 1'b0;
      period_stage_q <= PERIOD_RST;
      period_act_q   <= PERIOD_RST;
      dir_stage_q    <= 3'd0;
      dir_act_q      <= 3'd0;
      for (int i = 0; i < 3; i++) begin
         duty_stage_q[i] <= 16'd0;
         duty_act_q[i]   <= 16'd0;
      end
      counter_q      <= 16'd0;
      period_done_q  <= 1'b0;
      running_q      <= 1'b0;
      readdata_q     <= 16'd0;
      pwm_q          <= 3'd0;
      dir_out_q      <= 3'd0;
   endtask

   assign readdata = readdata_q;
   assign pwm_out  = pwm_q;
   assign dir_out  = dir_out_q;
   assign irq      = period_done_q & irq_en_q;

endmodule

// File: tb/tb_rover_pwm.sv
// Scoreboard bench for rover_pwm: bus reads and PWM duty windows are queued with
// their expected results and compared as the DUT produces them.
`timescale 1ns/1ps

module tb_rover_pwm;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        tick_in;
   logic        chipselect;
   logic        write_n;
   logic [2:0]  address;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic [2:0]  pwm_out;
   logic [2:0]  dir_out;
   logic        irq;

   typedef struct {
      string       tag;
      logic [15:0] exp;
   } sb_t;

   sb_t  sb_q[$];
   int   win_q[$];
   sb_t  mon_e;
   logic rd_valid = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   e0, w, c1;

   rover_pwm dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick_in    (tick_in),
      .chipselect (chipselect),
      .write_n    (write_n),
      .address    (address),
      .writedata  (writedata),
      .readdata   (readdata),
      .pwm_out    (pwm_out),
      .dir_out    (dir_out),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Read monitor: readdata is valid one clock after the address was presented.
   always @(posedge clk) begin
      if (rd_valid) begin
         #1;
         if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            chk(mon_e.tag, 32'(readdata), 32'(mon_e.exp));
         end
      end
   end

   // Timer tick lands on every clock edge whose index is a multiple of 100.
   initial begin
      tick_in = 1'b0;
      forever begin
         @(negedge clk);
         tick_in = ((cyc % 100) == 99);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, input logic [15:0] e, input string tag);
      sb_t s;
      s.tag = tag;
      s.exp = e;
      sb_q.push_back(s);
      address  = a;
      rd_valid = 1'b1;
      @(negedge clk);
      rd_valid = 1'b0;
      $display("read  addr=%0d expect=%0d (%s)", a, e, tag);
   endtask

   task automatic to_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic win(input string tag, input int idx, input int n, input int exp);
      int hi;
      int e;
      hi = 0;
      win_q.push_back(exp);
      for (int i = 0; i < n; i++) begin
         if (pwm_out[idx]) hi++;
         @(negedge clk);
      end
      e = win_q.pop_front();
      chk(tag, 32'(hi), 32'(e));
      $display("window %s: pwm[%0d] high %0d of %0d", tag, idx, hi, n);
   endtask

   task automatic wait_irq(input int limit, input string tag);
      int k;
      k = 0;
      while (!irq && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(irq), 32'd1);
   endtask

   function automatic int next_wrap(input int base, input int per);
      return base + per * ((cyc - base) / per + 1);
   endfunction

   initial begin
      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 3'd0;
      writedata  = 16'd0;
      repeat (3) @(negedge clk);
      chk("rst_pwm", 32'(pwm_out), 32'd0);
      chk("rst_dir", 32'(dir_out), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_rdata", 32'(readdata), 32'd0);
      reset_n = 1'b1;
      rd(3'd0, 16'd0,   "rst_status");
      rd(3'd1, 16'd0,   "rst_ctrl");
      rd(3'd2, 16'd999, "rst_period");
      rd(3'd3, 16'd0,   "rst_duty0");
      rd(3'd7, 16'd0,   "rst_cnt");

      // Free-running mode: period 9, duties 3 / 20 / 0, direction 101.
      wr(3'd2, 16'd9);
      wr(3'd3, 16'd3);
      wr(3'd4, 16'd20);
      wr(3'd5, 16'd0);
      wr(3'd6, 16'hfff5);
      rd(3'd6, 16'd5, "dir_unused_bits");
      wr(3'd7, 16'h0055);
      rd(3'd7, 16'd0, "cnt_readonly");
      chk("idle_pwm", 32'(pwm_out), 32'd0);
      wr(3'd1, 16'h0003);
      e0 = cyc;
      rd(3'd0, 16'd2, "run_status");
      wait_irq(40, "first_wrap_irq");
      chk("first_wrap_time", 32'(cyc), 32'(e0 + 10));
      chk("dir_active", 32'(dir_out), 32'd5);
      win("pwm0_duty3", 0, 10, 3);
      win("pwm1_over",  1, 10, 10);
      win("pwm2_zero",  2, 10, 0);

      // period_done re-sets every 10 clocks after a clear.
      w = next_wrap(e0, 10);
      to_cyc(w + 2);
      wr(3'd0, 16'd0);
      chk("irq_cleared", 32'(irq), 32'd0);
      to_cyc(w + 9);
      chk("irq_pre_wrap", 32'(irq), 32'd0);
      @(negedge clk);
      chk("irq_at_wrap", 32'(irq), 32'd1);

      // Clear on the wrap cycle: set wins.
      to_cyc(w + 19);
      wr(3'd0, 16'd0);
      chk("irq_set_wins", 32'(irq), 32'd1);
      rd(3'd0, 16'd3, "status_set_wins");

      // Mid-period duty write holds off until the wrap.
      w = next_wrap(e0, 10);
      to_cyc(w + 3);
      wr(3'd3, 16'd7);
      rd(3'd7, 16'd4, "cnt_mid");
      win("duty_old_tail", 0, 5, 0);
      win("duty_new", 0, 10, 7);
      to_cyc(w + 29);
      wr(3'd3, 16'd5);
      win("wrap_write_old", 0, 10, 7);
      win("wrap_write_new", 0, 10, 5);

      // Brake silences PWM but the counter keeps running.
      wr(3'd1, 16'h000b);
      win("brake_pwm0", 0, 10, 0);
      win("brake_pwm1", 1, 10, 0);
      rd(3'd7, 16'd1, "brake_cnt");
      chk("brake_dir", 32'(dir_out), 32'd5);
      wr(3'd1, 16'h0003);
      chk("unbrake_pwm1", 32'(pwm_out[1]), 32'd1);

      // Reset in the middle of a period.
      w = next_wrap(e0, 10);
      to_cyc(w + 5);
      reset_n = 1'b0;
      #1;
      chk("rst2_pwm", 32'(pwm_out), 32'd0);
      chk("rst2_dir", 32'(dir_out), 32'd0);
      chk("rst2_irq", 32'(irq), 32'd0);
      chk("rst2_rdata", 32'(readdata), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      rd(3'd2, 16'd999, "rst2_period");
      rd(3'd0, 16'd0,   "rst2_status");
      rd(3'd3, 16'd0,   "rst2_duty0");
      repeat (15) @(negedge clk);
      chk("rst2_no_irq", 32'(irq), 32'd0);

      // Tick mode: period 4, one step per 100 clocks.
      wr(3'd2, 16'd4);
      wr(3'd3, 16'd3);
      wr(3'd1, 16'h0007);
      wait_irq(700, "tick_first_wrap");
      c1 = cyc;
      chk("tick_wrap_align", 32'(c1 % 100), 32'd0);
      to_cyc(c1 + 50);
      rd(3'd7, 16'd0, "tick_cnt0");
      to_cyc(c1 + 150);
      rd(3'd7, 16'd1, "tick_cnt1");
      to_cyc(c1 + 250);
      rd(3'd7, 16'd2, "tick_cnt2");
      to_cyc(c1 + 260);
      wr(3'd0, 16'd0);
      chk("tick_irq_clr", 32'(irq), 32'd0);
      wait_irq(600, "tick_second_wrap");
      chk("tick_period", 32'(cyc - c1), 32'd500);

      // Disable: counter and running clear, PWM drops the next cycle.
      chk("dis_pwm0_before", 32'(pwm_out[0]), 32'd1);
      wr(3'd1, 16'h0000);
      chk("dis_pwm0", 32'(pwm_out[0]), 32'd0);
      rd(3'd7, 16'd0, "dis_cnt");
      rd(3'd0, 16'd1, "dis_status");

      // Period 0: wrap on every step; high only for duty >= 1.
      wr(3'd2, 16'd0);
      wr(3'd3, 16'd1);
      wr(3'd4, 16'd0);
      wr(3'd5, 16'd2);
      wr(3'd1, 16'h0001);
      win("p0_pwm0", 0, 10, 10);
      win("p0_pwm1", 1, 10, 0);
      win("p0_pwm2", 2, 10, 10);
      wr(3'd0, 16'd0);
      rd(3'd0, 16'd3, "p0_status");

      repeat (2) @(negedge clk);
      chk("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
